// File: rtl/imm_ext_unit_if.sv
// Purpose : bundles the decode-side immediate request and the extended results.
// Ports   : en/imm_sel/inst driven by the decode stage (master), imm_out/imm_out_q/
//           imm_sel_q driven by the immediate unit (slave).
interface imm_ext_unit_if;
  logic        en;         // pipeline advance for the registered copy
  logic [1:0]  imm_sel;    // immediate type select
  logic [26:0] inst;       // instruction bits [26:0]
  logic [31:0] imm_out;    // combinational extended immediate
  logic [31:0] imm_out_q;  // registered imm_out
  logic [1:0]  imm_sel_q;  // registered imm_sel

  modport master (
    output en,
    output imm_sel,
    output inst,
    input  imm_out,
    input  imm_out_q,
    input  imm_sel_q
  );

  modport slave (
    input  en,
    input  imm_sel,
    input  inst,
    output imm_out,
    output imm_out_q,
    output imm_sel_q
  );
endinterface

// File: rtl/imm_ext_unit.sv
// Purpose : extracts and sign/zero-extends the immediate field of an instruction word.
// Latency : imm_out is combinational (0 cycles); imm_out_q/imm_sel_q register it (1 cycle).
// Stall   : with en low the registered copy holds; imm_out keeps tracking its inputs.
// Ports   : clk, rst (sync, active-high, registers only), bus (imm_ext_unit_if.slave).
module imm_ext_unit (
  input  logic          clk,
  input  logic          rst,
  imm_ext_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IMM_I = 2'b00,  // 17-bit signed
    IMM_L = 2'b01,  // 22-bit signed
    IMM_U = 2'b10,  // 17-bit unsigned (logical immediates)
    IMM_J = 2'b11   // 27-bit signed (jumps)
  } imm_type_t;

  logic [31:0] imm_ext;

  // All four encodings are listed, and the default keeps the decode full even
  // if imm_sel ever carries X/Z in simulation.
  always_comb begin
    imm_ext = 32'h0;
    case (imm_type_t'(bus.imm_sel))
      IMM_I:   imm_ext = {{15{bus.inst[16]}}, bus.inst[16:0]};
      IMM_L:   imm_ext = {{10{bus.inst[21]}}, bus.inst[21:0]};
      IMM_U:   imm_ext = {15'b0, bus.inst[16:0]};
      IMM_J:   imm_ext = {{5{bus.inst[26]}}, bus.inst[26:0]};
      default: imm_ext = 32'h0;
    endcase
  end

  assign bus.imm_out = imm_ext;

  // Reset wins over en so a reset mid-stream always clears the pipeline copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.imm_out_q <= 32'h0;
      bus.imm_sel_q <= 2'b00;
    end else if (bus.en) begin
      bus.imm_out_q <= imm_ext;
      bus.imm_sel_q <= bus.imm_sel;
    end
  end

endmodule

// File: tb/tb_imm_ext_unit.sv
// Purpose : self-checking bench for imm_ext_unit (combinational decode + registered copy).
// Latency : checks imm_out immediately and imm_out_q/imm_sel_q one edge after capture.
// Stall   : exercises en-low hold and reset-over-enable priority with hand sequences.
module tb_imm_ext_unit;

  logic clk = 1'b0;
  logic rst;

  imm_ext_unit_if bus ();

  imm_ext_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic [26:0] inst;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // sel, inst, expected imm_out
    vecs[0]  = '{2'b00, 27'h0010000, 32'hFFFF0000};
    vecs[1]  = '{2'b00, 27'h0008000, 32'h00008000};
    vecs[2]  = '{2'b01, 27'h0200000, 32'hFFE00000};
    vecs[3]  = '{2'b01, 27'h0100000, 32'h00100000};
    vecs[4]  = '{2'b11, 27'h4000000, 32'hFC000000};
    vecs[5]  = '{2'b11, 27'h2000000, 32'h02000000};
    vecs[6]  = '{2'b10, 27'h7FFFFFF, 32'h0001FFFF};
    vecs[7]  = '{2'b00, 27'h7FFFFFF, 32'hFFFFFFFF};
    vecs[8]  = '{2'b01, 27'h7C00000, 32'h00000000};
    vecs[9]  = '{2'b10, 27'h0010000, 32'h00010000};
    vecs[10] = '{2'b00, 27'h7FE0000, 32'h00000000};
    vecs[11] = '{2'b11, 27'h0000001, 32'h00000001};
    vecs[12] = '{2'b01, 27'h03FFFFF, 32'hFFFFFFFF};
    vecs[13] = '{2'b00, 27'h000ABCD, 32'h0000ABCD};
    vecs[14] = '{2'b11, 27'h5555555, 32'hFD555555};
    vecs[15] = '{2'b11, 27'h7FFFFFF, 32'hFFFFFFFF};

    // Reset for two edges with en high; imm_out must not be forced by rst.
    rst = 1'b1;
    bus.en = 1'b1;
    bus.imm_sel = 2'b00;
    bus.inst = 27'h0010000;
    tick();
    tick();
    chk("rst_imm_out_q", bus.imm_out_q, 32'h0);
    chk("rst_imm_sel_q", {30'b0, bus.imm_sel_q}, 32'h0);
    chk("rst_imm_out_comb", bus.imm_out, 32'hFFFF0000);

    // First capture after release.
    rst = 1'b0;
    tick();
    chk("rel_imm_out_q", bus.imm_out_q, 32'hFFFF0000);
    chk("rel_imm_sel_q", {30'b0, bus.imm_sel_q}, 32'h0);

    // Stall: registers hold while imm_out tracks new inputs.
    bus.en = 1'b0;
    bus.inst = 27'h0008000;
    #1;
    chk("stall_imm_out", bus.imm_out, 32'h00008000);
    tick();
    bus.imm_sel = 2'b01;
    tick();
    tick();
    chk("stall_imm_out_q", bus.imm_out_q, 32'hFFFF0000);
    chk("stall_imm_sel_q", {30'b0, bus.imm_sel_q}, 32'h0);

    // Simultaneous sel/inst change captured after settling.
    bus.en = 1'b1;
    bus.imm_sel = 2'b01;
    bus.inst = 27'h0200000;
    tick();
    chk("simul_imm_out_q", bus.imm_out_q, 32'hFFE00000);
    chk("simul_imm_sel_q", {30'b0, bus.imm_sel_q}, 32'h1);

    // Reset mid-stream with en high clears on the next edge.
    rst = 1'b1;
    tick();
    chk("mid_rst_imm_out_q", bus.imm_out_q, 32'h0);
    chk("mid_rst_imm_sel_q", {30'b0, bus.imm_sel_q}, 32'h0);

    // Release reset with en low: nothing captured.
    rst = 1'b0;
    bus.en = 1'b0;
    bus.imm_sel = 2'b11;
    bus.inst = 27'h4000000;
    tick();
    chk("rel_noen_imm_out_q", bus.imm_out_q, 32'h0);
    bus.en = 1'b1;
    tick();
    chk("en_cap_imm_out_q", bus.imm_out_q, 32'hFC000000);
    chk("en_cap_imm_sel_q", {30'b0, bus.imm_sel_q}, 32'h3);

    // Table: combinational result, then the registered copy one edge later.
    for (int i = 0; i < 16; i++) begin
      bus.imm_sel = vecs[i].sel;
      bus.inst = vecs[i].inst;
      #1;
      chk($sformatf("vec%0d_imm_out", i), bus.imm_out, vecs[i].exp);
      tick();
      chk($sformatf("vec%0d_imm_out_q", i), bus.imm_out_q, vecs[i].exp);
      chk($sformatf("vec%0d_imm_sel_q", i), {30'b0, bus.imm_sel_q}, {30'b0, vecs[i].sel});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
